ps2_note_decoder: RTL

- Sits directly downstream of the PS/2 keyboard receiver and replaces its one-shot read pulser and two-deep history register.
- Synchronises the receiver's scan_ready, captures each scan code and returns the read acknowledge.
- Parses PS/2 set-2 prefixes (E0, F0, E1) into make/break key events.
- Maps 13 piano-layout keys to a held-note vector with typematic-repeat suppression, for the tone generator.

---
 rtl/ps2_note_decoder.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_note_decoder.sv
// PS/2 set-2 scan-code front end: synchronises and acknowledges receiver bytes,
// decodes E0/F0/E1 prefixes into key events and tracks 13 held piano notes.
module ps2_note_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
    parameter int unsigned CNT_W          = 22
) (
    input  logic        clock50,
    input  logic        reset,
    input  logic        scan_ready,
    input  logic [7:0]  scan_code,
    output logic        scan_read,
    output logic        key_valid,
    output logic [7:0]  key_code,
    output logic        key_extended,
    output logic        key_break,
    output logic        key_repeat,
    output logic        note_on,
    output logic        note_off,
    output logic [3:0]  note_index,
    output logic [12:0] note_held,
    output logic [3:0]  active_note,
    output logic        active_valid
);

    localparam int unsigned NOTES = 13;

    typedef enum logic [2:0] {ST_IDLE, ST_E0, ST_F0, ST_E0F0, ST_SKIP} state_t;

    state_t           state, state_n;
    logic [2:0]       skip_cnt, skip_cnt_n;
    logic [CNT_W-1:0] tmo_cnt;
    logic             s1, s2, s3;
    logic [7:0]       byte_q;
    logic             cap;
    logic             tmo_hit;
    logic             ev, ev_ext, ev_brk;
    logic             map_hit;
    logic [3:0]       map_idx;

    function automatic logic [4:0] note_map(input logic [7:0] c);
        case (c)
            8'h1C:   return {1'b1, 4'd0};
            8'h1D:   return {1'b1, 4'd1};
            8'h1B:   return {1'b1, 4'd2};
            8'h24:   return {1'b1, 4'd3};
            8'h23:   return {1'b1, 4'd4};
            8'h2B:   return {1'b1, 4'd5};
            8'h2C:   return {1'b1, 4'd6};
            8'h34:   return {1'b1, 4'd7};
            8'h35:   return {1'b1, 4'd8};
            8'h33:   return {1'b1, 4'd9};
            8'h3C:   return {1'b1, 4'd10};
            8'h3B:   return {1'b1, 4'd11};
            8'h42:   return {1'b1, 4'd12};
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [3:0] lowest_note(input logic [12:0] h);
        logic [3:0] r;
        r = 4'd0;
        for (int i = NOTES - 1; i >= 0; i--) begin
            if (h[i]) r = 4'(i);
        end
        return r;
    endfunction

    // Synchroniser; the byte is latched on the same edge the rising edge reaches s2.
    always_ff @(posedge clock50) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            byte_q <= 8'h00;
        end else begin
            s1 <= scan_ready;
            s2 <= s1;
            s3 <= s2;
            if (s1 && !s2) byte_q <= scan_code;
        end
    end

    assign cap     = s2 & ~s3;
    assign tmo_hit = (state != ST_IDLE) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign {map_hit, map_idx} = note_map(byte_q);

    always_ff @(posedge clock50) begin
        if (reset) begin
            state    <= ST_IDLE;
            skip_cnt <= 3'd0;
            tmo_cnt  <= '0;
        end else begin
            state    <= state_n;
            skip_cnt <= skip_cnt_n;
            if (cap || state == ST_IDLE || tmo_hit) tmo_cnt <= '0;
            else                                    tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_comb begin
        state_n    = state;
        skip_cnt_n = skip_cnt;
        ev         = 1'b0;
        ev_ext     = 1'b0;
        ev_brk     = 1'b0;
        if (cap) begin
            case (state)
                ST_IDLE: begin
                    case (byte_q)
                        8'hE0: state_n = ST_E0;
                        8'hF0: state_n = ST_F0;
                        8'hE1: begin
                            state_n    = ST_SKIP;
                            skip_cnt_n = 3'd7;
                        end
                        8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
                        default: ev = 1'b1;
                    endcase
                end
                ST_E0: begin
                    if (byte_q == 8'hF0) begin
                        state_n = ST_E0F0;
                    end else if (byte_q != 8'h12 && byte_q != 8'hE0) begin
                        ev      = 1'b1;
                        ev_ext  = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
                ST_F0: begin
                    ev      = 1'b1;
                    ev_brk  = 1'b1;
                    state_n = ST_IDLE;
                end
                ST_E0F0: begin
                    state_n = ST_IDLE;
                    if (byte_q != 8'h12) begin
                        ev     = 1'b1;
                        ev_ext = 1'b1;
                        ev_brk = 1'b1;
                    end
                end
                ST_SKIP: begin
                    skip_cnt_n = skip_cnt - 3'd1;
                    if (skip_cnt <= 3'd1) begin
                        skip_cnt_n = 3'd0;
                        state_n    = ST_IDLE;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end else if (tmo_hit) begin
            state_n = ST_IDLE;
        end
    end

    // Event outputs and held-note bookkeeping.
    always_ff @(posedge clock50) begin
        if (reset) begin
            scan_read    <= 1'b0;
            key_valid    <= 1'b0;
            key_code     <= 8'h00;
            key_extended <= 1'b0;
            key_break    <= 1'b0;
            key_repeat   <= 1'b0;
            note_on      <= 1'b0;
            note_off     <= 1'b0;
            note_index   <= 4'd0;
            note_held    <= 13'd0;
            active_note  <= 4'd0;
            active_valid <= 1'b0;
        end else begin
            scan_read    <= cap;
            key_valid    <= ev;
            note_on      <= 1'b0;
            note_off     <= 1'b0;
            active_note  <= lowest_note(note_held);
            active_valid <= |note_held;
            if (ev) begin
                key_code     <= byte_q;
                key_extended <= ev_ext;
                key_break    <= ev_brk;
                key_repeat   <= 1'b0;
                if (map_hit && !ev_ext) begin
                    if (!ev_brk) begin
                        if (note_held[map_idx]) begin
                            key_repeat <= 1'b1;
                        end else begin
                            note_held[map_idx] <= 1'b1;
                            note_on            <= 1'b1;
                            note_index         <= map_idx;
                        end
                    end else if (note_held[map_idx]) begin
                        note_held[map_idx] <= 1'b0;
                        note_off           <= 1'b1;
                        note_index         <= map_idx;
                    end
                end
            end
        end
    end

endmodule
